onchip_mem_arbiter: RTL and testbench

//  Shares the single-port 128K x 16 on-chip sample RAM between the audio voice fetch engine and
//  the Nios CPU Avalon-MM slave path. Audio reads have fixed priority; the CPU is stalled with

---
 rtl/onchip_mem_arb_pkg.sv | 23 ++
 rtl/onchip_mem_rd_tag_pipe.sv | 63 ++++++
 rtl/onchip_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// ============================================================================
//  Module   : onchip_mem_arb_pkg
//  Purpose  : Shared widths, read latency and owner tags for the on-chip
//             sample RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package onchip_mem_arb_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_AUD  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/onchip_mem_rd_tag_pipe.sv
// ============================================================================
//  Module   : onchip_mem_rd_tag_pipe
//  Purpose  : Tracks the owner of each in-flight RAM read and routes the
//             returning RAM data into the audio or CPU capture registers.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module onchip_mem_rd_tag_pipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int DATA_W = onchip_mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        issue_owner,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] aud_rdata,
    output logic              aud_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid
);

    owner_t r_tag [RD_LAT];
    owner_t w_ret_owner;

    assign w_ret_owner = r_tag[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= OWN_NONE;
            end
        end else begin
            r_tag[0] <= owner_t'(issue_owner);
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Capture registers hold the last returned word between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            aud_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            aud_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            aud_rvalid <= (w_ret_owner == OWN_AUD);
            cpu_rvalid <= (w_ret_owner == OWN_CPU);
            if (w_ret_owner == OWN_AUD) begin
                aud_rdata <= mem_readdata;
            end
            if (w_ret_owner == OWN_CPU) begin
                cpu_rdata <= mem_readdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
//  Module   : onchip_mem_arbiter
//  Purpose  : Fixed-priority arbiter sharing the single-port sample RAM
//             between audio voice fetch and the CPU Avalon-MM slave path.
//             Define ARB_STARVE_GUARD_EN to force a CPU slot after
//             MAX_AUD_BURST consecutive denied CPU cycles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W        = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W        = onchip_mem_arb_pkg::DATA_W,
    parameter int MAX_AUD_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aud_req,
    input  logic [ADDR_W-1:0]     aud_addr,
    output logic                  aud_gnt,
    output logic [DATA_W-1:0]     aud_rdata,
    output logic                  aud_rvalid,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    output logic                  cpu_waitrequest,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(MAX_AUD_BURST + 1);

    logic             w_cpu_req;
    logic             w_cpu_gnt;
    logic             w_force_cpu;
    owner_t           w_issue_owner;
    logic [CNT_W-1:0] r_starve_cnt;

    assign w_cpu_req       = cpu_read | cpu_write;
    assign aud_gnt         = aud_req & ~w_force_cpu;
    assign w_cpu_gnt       = w_cpu_req & ~aud_gnt;
    assign cpu_waitrequest = w_cpu_req & ~w_cpu_gnt;

    // Counter only advances while a CPU command is refused, so it never exceeds the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_cpu_gnt) begin
            r_starve_cnt <= '0;
        end else if (GUARD_EN && w_cpu_req) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_cpu = GUARD_EN & w_cpu_req & (r_starve_cnt == CNT_W'(MAX_AUD_BURST));

    // A simultaneous read+write is a write and produces no read return.
    always_comb begin
        w_issue_owner = OWN_NONE;
        if (aud_gnt) begin
            w_issue_owner = OWN_AUD;
        end else if (w_cpu_gnt && cpu_read && !cpu_write) begin
            w_issue_owner = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_clken      <= 1'b1;
        end else begin
            mem_clken      <= 1'b1;
            mem_chipselect <= aud_gnt | w_cpu_gnt;
            mem_write      <= w_cpu_gnt & cpu_write;
            if (aud_gnt) begin
                mem_address    <= aud_addr;
                mem_byteenable <= '1;
            end else if (w_cpu_gnt) begin
                mem_address    <= cpu_address;
                mem_byteenable <= cpu_byteenable;
                mem_writedata  <= cpu_writedata;
            end
        end
    end

    onchip_mem_rd_tag_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_tag_pipe (
        .clk          (clk),
        .reset        (reset),
        .issue_owner  (w_issue_owner),
        .mem_readdata (mem_readdata),
        .aud_rdata    (aud_rdata),
        .aud_rvalid   (aud_rvalid),
        .cpu_rdata    (cpu_readdata),
        .cpu_rvalid   (cpu_readdatavalid)
    );

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
// ============================================================================
//  Module   : tb_onchip_mem_arbiter
//  Purpose  : Self-checking bench for onchip_mem_arbiter with a RAM model,
//             a transaction-level reference model and directed checks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_onchip_mem_arbiter;

    localparam int AW = 17;
    localparam int DW = 16;
    localparam int MAX_BURST = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          aud_req = 1'b0;
    logic [AW-1:0] aud_addr = '0;
    logic          aud_gnt;
    logic [DW-1:0] aud_rdata;
    logic          aud_rvalid;
    logic [AW-1:0] cpu_address = '0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [DW-1:0] cpu_writedata = '0;
    logic [1:0]    cpu_byteenable = 2'b11;
    logic          cpu_waitrequest;
    logic [DW-1:0] cpu_readdata;
    logic          cpu_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [1:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_clken;
    logic [DW-1:0] mem_readdata = '0;

    onchip_mem_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .aud_req           (aud_req),
        .aud_addr          (aud_addr),
        .aud_gnt           (aud_gnt),
        .aud_rdata         (aud_rdata),
        .aud_rvalid        (aud_rvalid),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_writedata     (cpu_writedata),
        .cpu_byteenable    (cpu_byteenable),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_clken         (mem_clken),
        .mem_readdata      (mem_readdata)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM: address latched at the edge, q available during the following cycle.
    bit [DW-1:0] ram [0:(1<<AW)-1];
    initial forever begin
        @(posedge clk);
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model: transactions in issue order against a flat memory image.
    typedef struct {
        bit          is_aud;
        bit [DW-1:0] data;
        int          due;
    } rd_t;

    rd_t          pend[$];
    bit [DW-1:0]  mmem [0:(1<<AW)-1];
    int           cyc = 0;
    int           m_starve = 0;
    bit           e_cs = 0, e_wr = 0;
    bit [AW-1:0]  e_addr = '0;
    bit [1:0]     e_be = '0;
    bit [DW-1:0]  e_wd = '0;

    function automatic bit model_force(input bit c_req);
        return GUARD && c_req && (m_starve >= MAX_BURST);
    endfunction

    initial forever begin
        bit c_req, a_g, c_g;
        rd_t r;
        @(posedge clk);
        cyc++;
        if (reset) begin
            pend.delete();
            m_starve = 0;
            e_cs = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0;
        end else begin
            c_req = cpu_read || cpu_write;
            a_g   = aud_req && !model_force(c_req);
            c_g   = c_req && !a_g;
            e_cs  = a_g || c_g;
            e_wr  = c_g && cpu_write;
            if (a_g) begin
                e_addr = aud_addr; e_be = 2'b11;
                r.is_aud = 1; r.data = mmem[aud_addr]; r.due = cyc + 2;
                pend.push_back(r);
            end else if (c_g) begin
                e_addr = cpu_address; e_be = cpu_byteenable; e_wd = cpu_writedata;
                if (cpu_write) begin
                    if (cpu_byteenable[0]) mmem[cpu_address][7:0]  = cpu_writedata[7:0];
                    if (cpu_byteenable[1]) mmem[cpu_address][15:8] = cpu_writedata[15:8];
                end else begin
                    r.is_aud = 0; r.data = mmem[cpu_address]; r.due = cyc + 2;
                    pend.push_back(r);
                end
            end
            if (c_g) m_starve = 0;
            else if (c_req && GUARD) m_starve++;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        bit c_req, a_g, c_g, exp_av, exp_cv;
        bit [DW-1:0] exp_d;
        @(negedge clk);
        if (cyc > 0) begin
            c_req = cpu_read || cpu_write;
            a_g   = aud_req && !model_force(c_req) && !reset;
            if (reset) a_g = aud_req && !model_force(c_req);
            c_g   = c_req && !a_g;
            chk("aud_gnt", aud_gnt, a_g);
            chk("cpu_waitrequest", cpu_waitrequest, c_req && !c_g);
            chk("mem_chipselect", mem_chipselect, e_cs);
            chk("mem_write", mem_write, e_wr);
            chk("mem_clken", mem_clken, 1);
            if (e_cs) begin
                chk("mem_address", mem_address, e_addr);
                chk("mem_byteenable", mem_byteenable, e_be);
            end
            if (e_wr) chk("mem_writedata", mem_writedata, e_wd);
            exp_av = 0; exp_cv = 0; exp_d = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_av = pend[0].is_aud;
                exp_cv = !pend[0].is_aud;
                exp_d  = pend[0].data;
                void'(pend.pop_front());
            end
            chk("aud_rvalid", aud_rvalid, exp_av);
            chk("cpu_readdatavalid", cpu_readdatavalid, exp_cv);
            if (exp_av) chk("aud_rdata", aud_rdata, exp_d);
            if (exp_cv) chk("cpu_readdata", cpu_readdata, exp_d);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aud_req = 0; cpu_read = 0; cpu_write = 0;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1; cpu_read = 0;
        @(negedge clk);
        chk("wr_waitrequest", cpu_waitrequest, 0);
        tick();
        idle();
    endtask

    task automatic cpu_rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        cpu_address = a; cpu_read = 1; cpu_write = 0;
        @(negedge clk);
        chk({name, "_wait"}, cpu_waitrequest, 0);
        tick();
        idle();
        @(negedge clk);
        chk({name, "_rdv_early"}, cpu_readdatavalid, 0);
        tick();
        tick();
        @(negedge clk);
        chk({name, "_rdv"}, cpu_readdatavalid, 1);
        chk({name, "_data"}, cpu_readdata, exp);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = '0;
        a[3:0] = 4'($urandom_range(0, 15));
        a[AW-1] = 1'($urandom_range(0, 1));
        return a;
    endfunction

    initial begin
        bit aud_done, cpu_done;
        int r;
        tick(); tick();
        @(negedge clk);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_clken", mem_clken, 1);
        chk("rst_aud_rvalid", aud_rvalid, 0);
        reset = 0;
        tick();

        // 1: write then read back
        cpu_wr(17'h00010, 16'h1A2B, 2'b11);
        cpu_rd_chk("t1", 17'h00010, 16'h1A2B);
        tick();

        // 2: audio beats CPU, CPU accepted next cycle
        aud_req = 1; aud_addr = 17'h5; cpu_read = 1; cpu_address = 17'h10;
        @(negedge clk);
        chk("t2_aud_gnt", aud_gnt, 1);
        chk("t2_wait", cpu_waitrequest, 1);
        tick();
        aud_req = 0;
        @(negedge clk);
        chk("t2_wait_next", cpu_waitrequest, 0);
        tick();
        idle();
        repeat (4) tick();

        // 4: byte-lane write
        cpu_wr(17'h20, 16'h1234, 2'b11);
        cpu_wr(17'h20, 16'hFFEE, 2'b01);
        cpu_rd_chk("t4", 17'h20, 16'h12EE);
        tick();

        // 3: four back-to-back audio reads
        for (int i = 0; i < 4; i++) cpu_wr(AW'(i), DW'(16'h1000 + i), 2'b11);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin aud_req = 1; aud_addr = AW'(k); end
            else aud_req = 0;
            @(negedge clk);
            if (k < 4) chk("t3_gnt", aud_gnt, 1);
            if (k >= 3 && k <= 6) begin
                chk("t3_rvalid", aud_rvalid, 1);
                chk("t3_data", aud_rdata, 32'h1000 + k - 3);
            end else begin
                chk("t3_rvalid_idle", aud_rvalid, 0);
            end
            tick();
        end

        // 5: reset one clock after an audio grant drops the read
        aud_req = 1; aud_addr = 17'h1;
        tick();
        aud_req = 0; reset = 1;
        tick();
        @(negedge clk);
        chk("t5_cs", mem_chipselect, 0);
        chk("t5_wr", mem_write, 0);
        chk("t5_addr", mem_address, 0);
        chk("t5_be", mem_byteenable, 0);
        chk("t5_wd", mem_writedata, 0);
        chk("t5_clken", mem_clken, 1);
        chk("t5_aud_rdata", aud_rdata, 0);
        chk("t5_cpu_rdata", cpu_readdata, 0);
        chk("t5_cpu_rdv", cpu_readdatavalid, 0);
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_rvalid", aud_rvalid, 0);
            tick();
        end

        // 6: starvation behaviour with audio held
        aud_req = 1; aud_addr = 17'h2; cpu_read = 1; cpu_address = 17'h3;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (GUARD && i == MAX_BURST + 1) begin
                chk("t6_forced_aud_gnt", aud_gnt, 0);
                chk("t6_forced_wait", cpu_waitrequest, 0);
                tick();
                cpu_read = 0;
            end else begin
                chk("t6_aud_gnt", aud_gnt, 1);
                if (cpu_read) chk("t6_wait", cpu_waitrequest, 1);
                tick();
            end
        end
        idle();
        repeat (4) tick();

        // Randomized traffic with protocol-respecting holds
        aud_done = 1; cpu_done = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!aud_req || aud_done) begin
                aud_req  = ($urandom_range(0, 99) < 55);
                aud_addr = rand_addr();
            end
            if (!(cpu_read || cpu_write) || cpu_done) begin
                r = int'($urandom_range(0, 99));
                cpu_read  = (r < 30) || (r >= 95);
                cpu_write = (r >= 30 && r < 55) || (r >= 95);
                cpu_address    = rand_addr();
                cpu_writedata  = DW'($urandom);
                cpu_byteenable = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            aud_done = aud_gnt;
            cpu_done = !cpu_waitrequest;
            tick();
        end
        reset = 0;
        idle();
        repeat (4) tick();
        @(negedge clk);
        chk("drain_pending", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
